pulse_tx_pacer: RTL

PULSE_TX_PACER -- requirements
Module: pulse_tx_pacer

---
 rtl/pulse_tx_pacer.sv | 50 +++++
 1 files changed

// File: rtl/pulse_tx_pacer.sv
`timescale 1ns/1ps
// pulse_tx_pacer: queues single-cycle events and hands them to a slower domain one at a
// time as req_tgl transitions, waiting for the synchronized ack toggle before each next launch.
module pulse_tx_pacer #(
  parameter int CNT_W = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_fast,
  input  logic             rstn,
  input  logic             pulse_in,
  input  logic             ack_tgl,
  input  logic             ovf_clr,
  output logic             req_tgl,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);
  typedef enum logic {IDLE, WAIT_ACK} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic ack_s, launch, full, drop;
  assign ack_s  = ack_sync[SYNC_STAGES-1];
  assign launch = (state == IDLE) && (pending != '0);
  assign full   = &pending;
  assign drop   = pulse_in && full && !launch;
  assign busy   = (state == WAIT_ACK) || (pending != '0);
  always_ff @(posedge clk_fast or negedge rstn) begin
    if (!rstn) begin
      ack_sync <= '0;
      state    <= IDLE;
      req_tgl  <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_tgl};
      if (launch) begin
        req_tgl <= ~req_tgl;
        state   <= WAIT_ACK;
      end else if (state == WAIT_ACK && ack_s == req_tgl) begin
        state <= IDLE;
      end
      // a launch and an arriving pulse cancel, which also lets a full counter accept
      if (pulse_in && !launch && !full)
        pending <= pending + CNT_W'(1);
      else if (launch && !pulse_in)
        pending <= pending - CNT_W'(1);
      overflow <= drop | (overflow & ~ovf_clr);
    end
  end
endmodule
